wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count (index width 5).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port read_data_in  input  XLEN  load data from the MEM/WB register.
REQ-006 SHALL have port ALU_result_in  input  XLEN  ALU result from the MEM/WB register.
REQ-007 SHALL have port rd_in  input  5  destination register index from the MEM/WB register.
REQ-008 SHALL have port WB_reg_write_in  input  1  write-enable from the MEM/WB register.
REQ-009 SHALL have port WB_mem_to_reg_in  input  1  1 selects read_data_in, 0 selects ALU_result_in.
REQ-010 SHALL have ports rs1, rs2  input  5 each  ID-stage read indices.
REQ-011 SHALL have ports read_data_1, read_data_2  output  XLEN each  ID-stage operands.
REQ-012 SHALL have port wb_data_out  output  XLEN  selected writeback value, for forwarding.
REQ-013 SHALL have port retire_count  output  32  count of committed register writes.

Function
REQ-014 SHALL compute wb_data_out combinationally: WB_mem_to_reg_in ? read_data_in : ALU_result_in.
REQ-015 SHALL write wb_data_out into register rd_in at a rising edge when WB_reg_write_in=1, rd_in!=0 and reset=0.
REQ-016 SHALL never write register 0; read of index 0 SHALL return 0 on both ports.
REQ-017 SHALL return register contents combinationally on read_data_1/read_data_2 (zero-cycle read latency).
REQ-018 SHALL bypass: if WB_reg_write_in=1, rd_in!=0 and rs1==rd_in, read_data_1 SHALL equal wb_data_out in the same cycle; rs2 likewise, independently.
REQ-019 SHALL satisfy both read ports from one write when rs1==rs2==rd_in.
REQ-020 SHALL increment retire_count by 1 on each edge where a write per REQ-015 occurs; writes to x0 SHALL NOT count.
REQ-021 SHALL wrap retire_count from 0xFFFFFFFF to 0 without a flag.
REQ-022 SHALL not bypass or write when WB_reg_write_in=0, regardless of rd_in and data inputs.

Reset
REQ-023 SHALL, on an edge with reset=1, clear all registers and retire_count to 0; any coincident write SHALL be dropped.
REQ-024 SHALL, while reset=1, still drive read outputs per REQ-017/018 (zeros unless bypass applies); wb_data_out remains combinational.
REQ-025 SHALL resume writes on the first edge with reset=0; reset mid-sequence SHALL discard all prior contents.

Structure
REQ-026 SHALL place XLEN, NREGS, index width and the x0 index constant in the shared pipeline package/header used by the pipeline-register blocks.
REQ-027 SHALL instantiate one sub-module, wb_mux, implementing REQ-014; storage, bypass and counter stay in wb_regfile.

Verification
REQ-028 SHALL cover: reset, then write ALU_result_in=12345 to rd=31 (mem_to_reg=0) -> next cycle rs1=31 reads 12345, retire_count=1.
REQ-029 SHALL cover: mem_to_reg=1, read_data_in=1234, rd=5, rs1=rs2=5 same cycle -> both read ports =1234 before the edge (bypass), and after it.
REQ-030 SHALL cover: write 0xDEADBEEF to rd=0 -> rs1=0 reads 0, retire_count unchanged, no bypass.
REQ-031 SHALL cover: WB_reg_write_in=0, rd=7, rs1=7, data 99 -> read_data_1 keeps prior value of x7 (0 after reset), count unchanged.
REQ-032 SHALL cover: populate x1..x3, assert reset one cycle with a write pending to x4 -> all reads 0, retire_count=0, x4 not written.
REQ-033 SHALL cover: force retire_count to 0xFFFFFFFF via writes (or hierarchical preload), one more write -> retire_count=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared pipeline constants and types for the writeback stage
//               and the pipeline-register blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

    localparam int c_XLEN  = 32;
    localparam int c_NREGS = 32;
    localparam int c_IDX_W = 5;

    localparam logic [c_IDX_W-1:0] c_X0_IDX = '0;

    typedef logic [c_IDX_W-1:0] reg_idx_t;

endpackage : wb_regfile_pkg

`default_nettype wire

// File: rtl/wb_mux.sv
// ============================================================================
// Module      : wb_mux
// Description : Writeback source select between load data and ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic            i_mem_to_reg,
    input  logic [XLEN-1:0] i_read_data,
    input  logic [XLEN-1:0] i_alu_result,
    output logic [XLEN-1:0] o_wb_data
);

    assign o_wb_data = i_mem_to_reg ? i_read_data : i_alu_result;

endmodule : wb_mux

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage plus architectural register file with
//               same-cycle write-to-read bypass and a retired-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = c_XLEN,
    parameter int NREGS = c_NREGS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [XLEN-1:0]    read_data_in,
    input  logic [XLEN-1:0]    ALU_result_in,
    input  logic [c_IDX_W-1:0] rd_in,
    input  logic               WB_reg_write_in,
    input  logic               WB_mem_to_reg_in,
    input  logic [c_IDX_W-1:0] rs1,
    input  logic [c_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]    read_data_1,
    output logic [XLEN-1:0]    read_data_2,
    output logic [XLEN-1:0]    wb_data_out,
    output logic [31:0]        retire_count
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [31:0]     r_retire_count;
    logic            w_write_en;

    wb_mux #(
        .XLEN (XLEN)
    ) u_wb_mux (
        .i_mem_to_reg (WB_mem_to_reg_in),
        .i_read_data  (read_data_in),
        .i_alu_result (ALU_result_in),
        .o_wb_data    (wb_data_out)
    );

    // x0 is hardwired to zero, so a write aimed at it is simply not a write.
    assign w_write_en = WB_reg_write_in && (rd_in != c_X0_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_retire_count <= '0;
        end else if (w_write_en) begin
            r_regs[rd_in]  <= wb_data_out;
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    // The bypass hands the ID stage the value being committed this cycle.
    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        if (rs1 != c_X0_IDX) begin
            read_data_1 = (w_write_en && (rs1 == rd_in)) ? wb_data_out : r_regs[rs1];
        end
        if (rs2 != c_X0_IDX) begin
            read_data_2 = (w_write_en && (rs2 == rd_in)) ? wb_data_out : r_regs[rs2];
        end
    end

    assign retire_count = r_retire_count;

endmodule : wb_regfile

`default_nettype wire
